// File: rtl/sram_controller.sv
// sram_controller: sequences MEM-stage loads/stores onto a 16-bit async SRAM.
// Each 32-bit word moves as two halfword phases (LOW then HIGH), each lasting
// WAIT_CYCLES clocks; ready is held low for the whole transfer so the pipeline
// freezes until the word is done.
//
// Ports:
//   clk, rst          system clock (rising edge), async active-high reset
//   wr_en, rd_en      store / load request from the MEM stage
//   address           byte address; BASE_ADDR maps to SRAM word 0
//   write_data        store data
//   read_data         registered load data, held until the next load
//   ready             0 = freeze pipeline (combinational)
//   SRAM_*            board SRAM pins; CE/UB/LB tied active
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               is_write, write_nxt;
  logic [16:0]        word, word_nxt;
  logic [31:0]        wdata, wdata_nxt;
  logic [31:0]        rdata_nxt;
  logic [17:0]        addr_nxt;
  logic               we_n_nxt, oe_n_nxt;
  logic [15:0]        dq_out, dq_out_nxt;
  logic               dq_oe, dq_oe_nxt;
  logic [31:0]        offset;
  logic               unused_bits;

  // Word index relative to BASE_ADDR; wraps for addresses below the base.
  assign offset      = address - BASE_ADDR;
  assign unused_bits = ^{offset[31:19], offset[1:0]};

  assign ready     = ~(rd_en | wr_en) | (state == DONE);
  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // State register plus registered SRAM pins (glitch-free strobes).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_write  <= 1'b0;
      word      <= '0;
      wdata     <= '0;
      read_data <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      is_write  <= write_nxt;
      word      <= word_nxt;
      wdata     <= wdata_nxt;
      read_data <= rdata_nxt;
      SRAM_ADDR <= addr_nxt;
      SRAM_WE_N <= we_n_nxt;
      SRAM_OE_N <= oe_n_nxt;
      dq_out    <= dq_out_nxt;
      dq_oe     <= dq_oe_nxt;
    end
  end

  // Next state, read capture, and pin values for the upcoming cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    write_nxt  = is_write;
    word_nxt   = word;
    wdata_nxt  = wdata;
    rdata_nxt  = read_data;
    addr_nxt   = '0;
    we_n_nxt   = 1'b1;
    oe_n_nxt   = 1'b1;
    dq_out_nxt = '0;
    dq_oe_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (rd_en | wr_en) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
          write_nxt = wr_en;            // store wins when both are high
          word_nxt  = offset[18:2];
          wdata_nxt = write_data;
        end
      end
      LOW: begin
        if (cnt == LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          if (!is_write) rdata_nxt[15:0] = SRAM_DQ;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (cnt == LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
          if (!is_write) rdata_nxt[31:16] = SRAM_DQ;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if ((state_nxt == LOW) || (state_nxt == HIGH)) begin
      addr_nxt = {word_nxt, state_nxt == HIGH};
      if (write_nxt) begin
        dq_oe_nxt  = 1'b1;
        dq_out_nxt = (state_nxt == HIGH) ? wdata_nxt[31:16] : wdata_nxt[15:0];
        // Strobe released on the final cycle of the phase to hold data.
        we_n_nxt   = (cnt_nxt == LAST);
      end else begin
        oe_n_nxt = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed loads/stores against a small SRAM model,
// with expected halfword writes and completions queued by the stimulus and
// checked by an independent pin monitor.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:255];
  logic [33:0] exp_wr [$];
  int          exp_lat [$];
  logic [31:0] exp_rd [$];
  int          busy;
  logic        prev_we;

  sram_controller dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
    .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
    .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM read path.
  assign sram_dq = (!oe_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: SRAM write capture, halfword write check, completion check.
  always @(negedge clk) begin
    if (rst) begin
      busy    = 0;
      prev_we = 1'b1;
    end else begin
      if (!prev_we && we_n) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected actual=%h required=none", {sram_addr, sram_dq});
        end else begin
          chk("wr_addr_data", {30'd0, sram_addr, sram_dq}, {30'd0, exp_wr.pop_front()});
        end
      end
      prev_we = we_n;
      if (!we_n) mem[sram_addr[7:0]] = sram_dq;
      if (wr_en || rd_en) begin
        if (!ready) begin
          busy++;
        end else begin
          if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected actual=%h required=none", read_data);
          end else begin
            chk("latency", 64'(busy), 64'(exp_lat.pop_front()));
            chk("read_data", {32'd0, read_data}, {32'd0, exp_rd.pop_front()});
          end
          busy = 0;
        end
      end
    end
  end

  // Issue one request (caller at posedge+1); checks strobe pattern per cycle.
  task automatic do_op(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [17:0] lo,
                       input logic [31:0] exp_data, input string name);
    int   bad;
    logic done;
    logic exp_we, exp_oe;
    if (wr) begin
      exp_wr.push_back({lo, wd[15:0]});
      exp_wr.push_back({lo | 18'd1, wd[31:16]});
    end
    exp_lat.push_back(7);
    exp_rd.push_back(exp_data);
    wr_en = wr; rd_en = rd; address = a; write_data = wd;
    bad = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      exp_we = !(wr && (c == 1 || c == 2 || c == 4 || c == 5));
      exp_oe = !(!wr && rd && c >= 1 && c <= 6);
      if (we_n !== exp_we || oe_n !== exp_oe) bad++;
      if (ready) done = 1'b1;
    end
    chk({name, "_pins"}, 64'(bad), 64'd0);
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_ready required=ready", name);
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read_data", {32'd0, read_data}, 64'd0);
    chk("rst_pins", {43'd0, sram_addr, we_n, oe_n, ready}, {43'd0, 18'd0, 3'b111});
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle", {61'd0, ready, we_n, oe_n}, 64'd7);
    end
    @(posedge clk); #1;

    do_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0, 32'h0, "store");
    mem[2] = 16'h1234; mem[3] = 16'hABCD;
    do_op(1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hABCD1234, "load");
    repeat (3) begin
      @(negedge clk);
      chk("load_hold", {32'd0, read_data}, {32'd0, 32'hABCD1234});
    end
    @(posedge clk); #1;

    do_op(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 18'd4, 32'hABCD1234, "b2b_store");
    do_op(1'b0, 1'b1, 32'd1032, 32'h0, 18'd4, 32'hCAFEF00D, "b2b_load");
    do_op(1'b1, 1'b1, 32'd1036, 32'h0BAD0FF1, 18'd6, 32'hCAFEF00D, "prio");
    do_op(1'b1, 1'b0, 32'd1020, 32'h11112222, 18'h3FFFE, 32'hCAFEF00D, "wrap");

    // Reset in the first HIGH cycle of a store: only the low half lands.
    exp_wr.push_back({18'd8, 16'h7788});
    wr_en = 1'b1; address = 32'd1040; write_data = 32'h55667788;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_pins", {45'd0, sram_addr, we_n}, {45'd0, 18'd0, 1'b1});
    chk("rst_mid_oe", {63'd0, oe_n}, 64'd1);
    chk("rst_mid_read_data", {32'd0, read_data}, 64'd0);
    wr_en = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst", {62'd0, ready, we_n}, 64'd3);
    @(posedge clk); #1;
    do_op(1'b0, 1'b1, 32'd1040, 32'h0, 18'd8, 32'h00007788, "rst_load");

    repeat (2) @(negedge clk);
    chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_rd.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sequences every data-memory access issued by the MEM stage (mem_rd / mem_wr from the control unit) onto an external 16-bit asynchronous SRAM.
- Each 32-bit word is split into two halfword transfers, each stretched over WAIT_CYCLES clocks.
- Drops ready for the whole transfer; the pipeline freeze logic consumes ready to hold all stages.
- Sits between the MEM stage and the board SRAM pins.

Parameters:
- WAIT_CYCLES, 3, clocks per halfword phase; legal range 2..15.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  store request from MEM stage.
- rd_en  in  1  load request from MEM stage.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (Rm value).
- read_data  out  32  registered load data.
- ready  out  1  0 = freeze pipeline.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM halfword address.
- SRAM_WE_N  out  1  write enable, active low.
- SRAM_OE_N  out  1  output enable, active low.
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  tied 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values (also the idle values):
  - state IDLE, phase counter 0, read_data 0.
  - SRAM_WE_N 1, SRAM_OE_N 1, SRAM_ADDR 0, SRAM_DQ high-Z.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, 32-bit subtract, upper bits discarded.
  - LOW phase: SRAM_ADDR = {word[16:0], 0}. HIGH phase: SRAM_ADDR = {word[16:0], 1}.
  - address[1:0] is ignored.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE -> LOW when rd_en | wr_en. The operation type is latched at this edge.
  - LOW -> HIGH after WAIT_CYCLES clocks in LOW (counter 0..WAIT_CYCLES-1, cleared on every phase entry).
  - HIGH -> DONE after WAIT_CYCLES clocks in HIGH.
  - DONE -> IDLE unconditionally after 1 clock.
- ready is combinational: ready = ~(rd_en | wr_en) | (state == DONE).
  - ready is 1 in IDLE with no request and 1 in DONE; 0 otherwise.
- Latency: request first seen in IDLE at cycle 0 -> ready = 1 at cycle 2*WAIT_CYCLES+1 (cycle 7 for the default). The pipeline advances on that edge.
- Write phases:
  - SRAM_DQ driven with write_data[15:0] in LOW and write_data[31:16] in HIGH.
  - SRAM_WE_N = 0 on counter values 0..WAIT_CYCLES-2 and 1 on the last cycle of each phase (data hold).
  - SRAM_OE_N stays 1.
- Read phases:
  - SRAM_OE_N = 0 and SRAM_DQ high-Z in LOW and HIGH.
  - read_data[15:0] captured from SRAM_DQ on the last LOW cycle; read_data[31:16] on the last HIGH cycle.
  - read_data holds its value until the next read overwrites it; writes never modify it.
- Outputs in IDLE and DONE: SRAM_WE_N = 1, SRAM_OE_N = 1, DQ high-Z.
- rd_en and wr_en both high: write has priority (treated as a store).
- Request drops mid-transfer: the latched transfer completes; ready follows the formula, so it goes 1 immediately.
- Back-to-back requests: request still high in DONE is not re-accepted; a request present on the following IDLE cycle starts a new transfer. Exactly one transfer per instruction.
- rst asserted mid-transfer: immediate return to the reset values, with WE_N forced 1 asynchronously. No partial write is completed.
- Address below BASE_ADDR wraps modulo 2^17 words; no error is flagged.

Test Plan:
- Idle: rd_en = wr_en = 0 for 10 cycles -> ready = 1 throughout; WE_N = OE_N = 1; DQ high-Z.
- Store: wr_en = 1, address = 1024, write_data = 0xDEADBEEF.
  - ready low cycles 0..6, high at cycle 7.
  - SRAM_ADDR 0 with DQ = 0xBEEF, then SRAM_ADDR 1 with DQ = 0xDEAD.
  - WE_N low for 2 of every 3 cycles in each phase.
- Load: SRAM model holds 0x1234 at addr 2 and 0xABCD at addr 3; rd_en = 1, address = 1028.
  - OE_N low cycles 1..6.
  - read_data = 0xABCD1234 at cycle 7, unchanged afterward.
- Back-to-back: store to 1032, then a load from 1032 in the next IDLE cycle -> two separate 7-cycle freezes; load returns the stored word.
- Reset mid-store: rst pulsed at cycle 4 of a store -> WE_N = 1 and DQ high-Z within the same cycle; state IDLE; read_data = 0.
- Priority: rd_en = wr_en = 1 -> write sequence on the pins; OE_N never low; read_data unchanged.
